pc_gen: RTL and testbench



---
 rtl/pc_gen_if.sv | 21 ++
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch handshake between pc_gen and instruction fetch.
// Ports: pc, pc_valid (request) and fetch_ready (accept).
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            fetch_ready;

  modport master (
    output pc,
    output pc_valid,
    input  fetch_ready
  );

  modport slave (
    input  pc,
    input  pc_valid,
    output fetch_ready
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: registered PC with RUN/HALTED/TRAP state and instret counter.
// Ports: clk, rst (sync, high), fetch (pc/pc_valid/fetch_ready),
//   cnd, jump, jump_reg, halt, resume, imm, alu_result -> halted,
//   trap, trap_target, instret. PC_GEN_TRAP_EN enables the
//   misaligned-redirect trap; otherwise targets are word-aligned.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst,
  pc_gen_if.master         fetch,
  input  logic             cnd,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             halt,
  input  logic             resume,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  alu_result,
  output logic             halted,
  output logic             trap,
  output logic [XLEN-1:0]  trap_target,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    TRAP   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  target;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             advance;
  logic             redirect;
`ifdef PC_GEN_TRAP_EN
  logic [XLEN-1:0]  tt_q;
  logic [XLEN-1:0]  tt_d;
`endif

  assign advance  = (state_q == RUN) && fetch.fetch_ready;
  assign redirect = jump_reg | jump | cnd;
  assign pc_seq   = pc_q + XLEN'(4);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    target = pc_seq;
    if (jump_reg) begin
      target = alu_result & ~XLEN'(1);
    end else if (jump | cnd) begin
      target = pc_q + imm;
    end else if (halt) begin
      target = pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef PC_GEN_TRAP_EN
    tt_d    = tt_q;
`endif
    unique case (state_q)
      RUN: begin
        if (advance) begin
`ifdef PC_GEN_TRAP_EN
          if (redirect && (target[1:0] != 2'b00)) begin
            // trapping instruction does not retire
            state_d = TRAP;
            tt_d    = target;
          end else if (!redirect && halt) begin
            state_d = HALTED;
            cnt_d   = cnt_inc;
          end else begin
            pc_d  = target;
            cnt_d = cnt_inc;
          end
`else
          if (!redirect && halt) begin
            state_d = HALTED;
            cnt_d   = cnt_inc;
          end else begin
            pc_d  = target & ~XLEN'(3);
            cnt_d = cnt_inc;
          end
`endif
        end
      end
      HALTED: begin
        if (resume) begin
          pc_d    = pc_seq;
          state_d = RUN;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
`ifdef PC_GEN_TRAP_EN
      tt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef PC_GEN_TRAP_EN
      tt_q    <= tt_d;
`endif
    end
  end

  assign fetch.pc       = pc_q;
  assign fetch.pc_valid = (state_q == RUN);
  assign halted         = (state_q == HALTED);
  assign instret        = cnt_q;
`ifdef PC_GEN_TRAP_EN
  assign trap           = (state_q == TRAP);
  assign trap_target    = tt_q;
`else
  assign trap           = 1'b0;
  assign trap_target    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: vector table plus hand sequences for pc_gen.
// Covers reset, stall, priority, halt/resume, wrap, trap, saturation.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fr;
  logic        cnd, jump, jreg, halt, resume;
  logic [31:0] imm, alu;

  logic        halted1, trap1, halted2, trap2;
  logic [31:0] tt1, tt2;
  logic [63:0] cnt1;
  logic [3:0]  cnt2;

  int total = 0;
  int bad   = 0;

  pc_gen_if #(.XLEN(32)) f1 ();
  pc_gen_if #(.XLEN(32)) f2 ();

  assign f1.fetch_ready = fr;
  assign f2.fetch_ready = fr;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h100), .CNT_W(64)
  ) dut (
    .clk(clk), .rst(rst), .fetch(f1),
    .cnd(cnd), .jump(jump), .jump_reg(jreg),
    .halt(halt), .resume(resume),
    .imm(imm), .alu_result(alu),
    .halted(halted1), .trap(trap1),
    .trap_target(tt1), .instret(cnt1)
  );

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h100), .CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .fetch(f2),
    .cnd(cnd), .jump(jump), .jump_reg(jreg),
    .halt(halt), .resume(resume),
    .imm(imm), .alu_result(alu),
    .halted(halted2), .trap(trap2),
    .trap_target(tt2), .instret(cnt2)
  );

  typedef struct {
    logic        rst, fr, cnd, jump, jreg, halt, resume;
    logic [31:0] imm, alu;
    logic [31:0] pc;
    logic        valid, hlt;
    logic [63:0] cnt;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(
    input logic r, f, c, j, jr, h, rs,
    input logic [31:0] im, al, p,
    input logic v, hl,
    input logic [63:0] n
  );
    vec_t t;
    t.rst = r; t.fr = f; t.cnd = c; t.jump = j;
    t.jreg = jr; t.halt = h; t.resume = rs;
    t.imm = im; t.alu = al; t.pc = p;
    t.valid = v; t.hlt = hl; t.cnt = n;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, c, j, jr, h, rs,
                       input logic [31:0] im, al);
    rst = r; fr = f; cnd = c; jump = j;
    jreg = jr; halt = h; resume = rs;
    imm = im; alu = al;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //          r f c j jr h rs imm           alu
    tbl[0]  = mk(1,0,0,0,0,0,0, 32'h0,        32'h0,
                 32'h100, 1, 0, 0);
    tbl[1]  = mk(0,1,0,0,0,0,0, 32'h0,        32'h0,
                 32'h104, 1, 0, 1);
    tbl[2]  = mk(0,1,0,0,0,0,0, 32'h0,        32'h0,
                 32'h108, 1, 0, 2);
    tbl[3]  = mk(0,1,0,0,0,0,0, 32'h0,        32'h0,
                 32'h10C, 1, 0, 3);
    tbl[4]  = mk(0,1,0,0,1,0,0, 32'h0,        32'h200,
                 32'h200, 1, 0, 4);
    tbl[5]  = mk(0,0,1,0,0,0,0, 32'h40,       32'h0,
                 32'h200, 1, 0, 4);
    tbl[6]  = mk(0,0,1,0,0,0,0, 32'h40,       32'h0,
                 32'h200, 1, 0, 4);
    tbl[7]  = mk(0,1,1,0,0,0,0, 32'h40,       32'h0,
                 32'h240, 1, 0, 5);
    tbl[8]  = mk(0,1,0,1,1,1,0, 32'h10,       32'h1235,
                 32'h1234, 1, 0, 6);
    tbl[9]  = mk(0,1,0,1,0,0,0, 32'hFFFFFFF0, 32'h0,
                 32'h1224, 1, 0, 7);
    tbl[10] = mk(0,1,0,0,1,0,0, 32'h0,        32'h300,
                 32'h300, 1, 0, 8);
    tbl[11] = mk(0,1,0,0,0,1,0, 32'h0,        32'h0,
                 32'h300, 0, 1, 9);
    tbl[12] = mk(0,1,0,0,0,1,0, 32'h0,        32'h0,
                 32'h300, 0, 1, 9);
    tbl[13] = mk(0,1,0,0,0,1,0, 32'h0,        32'h0,
                 32'h300, 0, 1, 9);
    tbl[14] = mk(0,1,0,0,0,1,0, 32'h0,        32'h0,
                 32'h300, 0, 1, 9);
    tbl[15] = mk(0,1,0,0,0,0,1, 32'h0,        32'h0,
                 32'h304, 1, 0, 9);
    tbl[16] = mk(0,0,0,0,0,0,1, 32'h0,        32'h0,
                 32'h304, 1, 0, 9);
    tbl[17] = mk(0,1,0,0,0,0,1, 32'h0,        32'h0,
                 32'h308, 1, 0, 10);
    tbl[18] = mk(0,1,1,0,0,1,0, 32'h8,        32'h0,
                 32'h310, 1, 0, 11);
    tbl[19] = mk(0,1,0,0,1,0,0, 32'h0,        32'hFFFFFFFC,
                 32'hFFFFFFFC, 1, 0, 12);
    tbl[20] = mk(0,1,0,0,0,0,0, 32'h0,        32'h0,
                 32'h0, 1, 0, 13);
    tbl[21] = mk(0,0,0,0,0,1,0, 32'h0,        32'h0,
                 32'h0, 1, 0, 13);
    tbl[22] = mk(0,1,0,0,0,1,0, 32'h0,        32'h0,
                 32'h0, 0, 1, 14);
    tbl[23] = mk(1,1,0,0,0,1,0, 32'h0,        32'h0,
                 32'h100, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].fr, tbl[i].cnd,
            tbl[i].jump, tbl[i].jreg, tbl[i].halt,
            tbl[i].resume, tbl[i].imm, tbl[i].alu);
      chk($sformatf("v%0d pc", i), 64'(f1.pc),
          64'(tbl[i].pc));
      chk($sformatf("v%0d valid", i), 64'(f1.pc_valid),
          64'(tbl[i].valid));
      chk($sformatf("v%0d halted", i), 64'(halted1),
          64'(tbl[i].hlt));
      chk($sformatf("v%0d instret", i), cnt1, tbl[i].cnt);
      chk($sformatf("v%0d trap", i), 64'(trap1), 64'd0);
    end

`ifdef PC_GEN_TRAP_EN
    drive(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h400);
    chk("tr pre pc", 64'(f1.pc), 64'h400);
    drive(0, 1, 0, 1, 0, 0, 0, 32'h6, 32'h0);
    chk("tr trap", 64'(trap1), 64'd1);
    chk("tr target", 64'(tt1), 64'h406);
    chk("tr pc", 64'(f1.pc), 64'h400);
    chk("tr valid", 64'(f1.pc_valid), 64'd0);
    chk("tr halted", 64'(halted1), 64'd0);
    chk("tr instret", cnt1, 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 0, 1, 32'h4, 32'h0);
      chk("tr stuck", 64'(trap1), 64'd1);
      chk("tr stuck pc", 64'(f1.pc), 64'h400);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("tr rst pc", 64'(f1.pc), 64'h100);
    chk("tr rst trap", 64'(trap1), 64'd0);
    chk("tr rst target", 64'(tt1), 64'd0);
    chk("tr rst valid", 64'(f1.pc_valid), 64'd1);
`else
    drive(0, 1, 0, 1, 0, 0, 0, 32'h6, 32'h0);
    chk("al jal pc", 64'(f1.pc), 64'h104);
    chk("al trap", 64'(trap1), 64'd0);
    chk("al target", 64'(tt1), 64'd0);
    chk("al instret", cnt1, 64'd1);
    drive(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h403);
    chk("al jalr pc", 64'(f1.pc), 64'h400);
    drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("al rst pc", 64'(f1.pc), 64'h100);
`endif

    chk("sat rst", 64'(cnt2), 64'd0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      if (i == 13) chk("sat 14", 64'(cnt2), 64'hE);
      if (i == 14) chk("sat 15", 64'(cnt2), 64'hF);
    end
    chk("sat 20", 64'(cnt2), 64'hF);
    chk("sat wide", cnt1, 64'd20);
    chk("sat pc", 64'(f1.pc), 64'h150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
